image_window_gen: RTL and testbench
===================================

# image_window_gen

Parametrised sliding-window generator for the corner-detection front end. It accepts a raster pixel stream with valid/ready handshaking and buffers WIN-1 full image lines plus a WIN-column shift window. For every accepted pixel that completes a full in-image window, it emits one WIN×WIN window. It sits between the pixel source and the gradient/response stages, and adds to the fixed 6×6/480-wide generator: back-pressure, frame resync, window-last marking and generic sizing.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 480, pixels per line (≥ WIN)
- IMG_H, 360, lines per frame (≥ WIN)
- WIN, 6, window edge length, legal 2..8
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- pixel  in  DATA_W  input pixel, raster order
- pixel_valid  in  1  pixel present
- pixel_ready  out  1  block can accept; = !window_valid | window_ready
- frame_sync  in  1  qualifies the accepted pixel as (row 0, col 0)
- window  out  WIN*WIN*DATA_W  element [r][c] at bits (r*WIN+c)*DATA_W +: DATA_W; r=0 oldest line, c=0 leftmost column
- window_valid  out  1  window holds a valid window
- window_ready  in  1  downstream accepts
- window_last  out  1  qualifies the final window of a frame
- win_row  out  $clog2(IMG_H)  image row of window[0][0] (see Configuration)
- win_col  out  $clog2(IMG_W)  image column of window[0][0]

## Operation
- Accept = pixel_valid & pixel_ready. All state advances only on accept; with no accept, everything holds.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the accepted pixel.
  - col wraps to 0 after IMG_W-1, which increments row.
  - row wraps to 0 after IMG_H-1, starting a new frame.
- frame_sync on an accepted pixel forces that pixel to be treated as (0,0); the counters continue from (0,1). frame_sync without accept is ignored.
- Line storage: WIN-1 line memories of IMG_W × DATA_W, rotating by line. On accept at col c, column c of the previous WIN-1 lines is read and the new pixel replaces the oldest line's entry.
- The column shift window shifts left by one on accept, loading the WIN-1 stored pixels plus the new pixel into column WIN-1.
- Emission: an accepted pixel at (row, col) with row ≥ WIN-1 and col ≥ WIN-1 produces a window where window[r][c] = pixel(row-WIN+1+r, col-WIN+1+c).
  - Windows per frame: (IMG_H-WIN+1)*(IMG_W-WIN+1).
  - No windows straddle line or frame boundaries, and no padding is applied.
- window_last = 1 on the window produced by pixel (IMG_H-1, IMG_W-1).
- Buffer contents are never cleared. Rows 0..WIN-2 after reset or frame_sync only fill the buffers, so no stale data is ever emitted.

## Timing
- Reset values: pixel_ready=1, window_valid=0, window_last=0, window=0, win_row=0, win_col=0, counters=0.
- Latency: an emitting pixel accepted in cycle t gives window_valid=1 from t+1.
- Hold rule: window_valid & !window_ready holds window, window_last and coordinates stable, and pixel_ready=0.
- Throughput: one window per cycle while window_ready=1, with no bubbles.
- Output handshake completes on window_valid & window_ready. Without a new emitting accept in that same cycle, window_valid falls in the next cycle.
- Simultaneous output handshake and emitting accept: the new window is loaded and window_valid stays 1.
- frame_sync mid-line or mid-frame: restarts the fill phase. The first window appears at the (WIN-1, WIN-1) pixel after sync.
- Reset asserted mid-frame: outputs return to reset values asynchronously. The first window after release needs WIN-1 full lines again.

## Configuration
- WIN_COORD_EN defined: win_row/win_col register the row/col of window[0][0] (row-WIN+1, col-WIN+1) alongside each window and hold with it.
- WIN_COORD_EN undefined: the win_row/win_col ports remain but are tied to 0, and no coordinate registers are built.

## Test plan
Parameters for all scenarios: IMG_W=8, IMG_H=6, WIN=3, pixel = row*16+col, unless stated.
- First window: stream one frame with window_ready=1 and frame_sync on the first pixel → first window one cycle after accepting 0x22; rows {00,01,02}/{10,11,12}/{20,21,22}; win_row=0, win_col=0 with WIN_COORD_EN.
- Window count: full frame → exactly 24 windows, no window for col<2 or row<2, window_last only on the window ending at 0x57, two back-to-back frames → 48 windows.
- Backpressure: random window_ready with 30% duty → pixel_ready=0 whenever a window is held, no window lost or duplicated, sequence identical to the unstalled run.
- Resync: frame_sync at pixel (3,4) → no window until the 3rd post-sync line, column 2; the first such window contains only post-sync pixels.
- Reset mid-frame: assert reset at pixel (4,5) for 2 cycles → window_valid drops to 0 immediately; the next frame reproduces the first-window result exactly.
- Size sweep: WIN=8, IMG_W=16, IMG_H=8 → 9 windows, the last one with window[7][7]=0x7F.

Source files
------------

// File: rtl/image_window_gen.sv
// Sliding WIN x WIN window generator over a raster pixel stream, with valid/ready on both sides.
// Define WIN_COORD_EN to register the image position of window[0][0] on win_row/win_col.
module image_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 360,
    parameter int WIN    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         pixel,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    input  logic                      frame_sync,
    output logic [WIN*WIN*DATA_W-1:0] window,
    output logic                      window_valid,
    input  logic                      window_ready,
    output logic                      window_last,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col
);
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int LINES = WIN - 1;
    localparam int PW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int IW    = PW + 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(LINES - 1);
    localparam logic [IW-1:0] IDX_WRAP  = IW'(LINES);

    logic [RW-1:0] rowCnt, curRow, nextRow;
    logic [CW-1:0] colCnt, curCol, nextCol;
    logic [PW-1:0] linePtr, curPtr, nextPtr;
    logic          accept, emit, lastPix;

    logic [DATA_W-1:0] lineMem   [LINES][IMG_W];
    logic [DATA_W-1:0] lineRd    [LINES];
    logic [DATA_W-1:0] shiftP0   [WIN][WIN];
    logic [DATA_W-1:0] shiftNext [WIN][WIN];
    logic [WIN*WIN*DATA_W-1:0] nextFlat;

    logic                      vldP1;
    logic                      lastP1;
    logic [WIN*WIN*DATA_W-1:0] windowP1;

    assign pixel_ready = !vldP1 || window_ready;
    assign accept      = pixel_valid && pixel_ready;

    // frame_sync relabels the accepted pixel as (0,0) and restarts the line rotation.
    always_comb begin
        curRow  = frame_sync ? '0 : rowCnt;
        curCol  = frame_sync ? '0 : colCnt;
        curPtr  = frame_sync ? '0 : linePtr;
        nextCol = (curCol == COL_LAST) ? '0 : curCol + 1'b1;
        nextRow = curRow;
        nextPtr = curPtr;
        if (curCol == COL_LAST) begin
            nextRow = (curRow == ROW_LAST) ? '0 : curRow + 1'b1;
            nextPtr = (curPtr == PTR_LAST) ? '0 : curPtr + 1'b1;
        end
    end

    assign emit    = accept && (curRow >= ROW_FIRST) && (curCol >= COL_FIRST);
    assign lastPix = (curRow == ROW_LAST) && (curCol == COL_LAST);

    // The line at curPtr is the oldest; the others follow in rotation order.
    always_comb begin
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = 0; k < LINES; k++) begin
            idx = {1'b0, curPtr} + IW'(k);
            if (idx >= IDX_WRAP) idx = idx - IDX_WRAP;
            lineRd[k] = '0;
            for (int m = 0; m < LINES; m++) begin
                if (idx == IW'(m)) lineRd[k] = lineMem[m][curCol];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int m = 0; m < LINES; m++) begin
                if (curPtr == PW'(m)) lineMem[m][curCol] <= pixel;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
                shiftNext[r][c] = shiftP0[r][c+1];
            end
        end
        for (int r = 0; r < WIN - 1; r++) begin
            shiftNext[r][WIN-1] = lineRd[r];
        end
        shiftNext[WIN-1][WIN-1] = pixel;
    end

    always_comb begin
        nextFlat = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                nextFlat[(r*WIN+c)*DATA_W +: DATA_W] = shiftNext[r][c];
            end
        end
    end

    // ---- stage p0: column shift window ----
    always_ff @(posedge clk) begin
        if (accept) shiftP0 <= shiftNext;
    end

    // ---- stage p1: output window register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rowCnt   <= '0;
            colCnt   <= '0;
            linePtr  <= '0;
            vldP1    <= 1'b0;
            lastP1   <= 1'b0;
            windowP1 <= '0;
        end else begin
            if (accept) begin
                rowCnt  <= nextRow;
                colCnt  <= nextCol;
                linePtr <= nextPtr;
            end
            if (emit) begin
                vldP1    <= 1'b1;
                lastP1   <= lastPix;
                windowP1 <= nextFlat;
            end else if (window_ready) begin
                vldP1 <= 1'b0;
            end
        end
    end

    assign window       = windowP1;
    assign window_valid = vldP1;
    assign window_last  = lastP1;

`ifdef WIN_COORD_EN
    logic [RW-1:0] rowP1;
    logic [CW-1:0] colP1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rowP1 <= '0;
            colP1 <= '0;
        end else if (emit) begin
            rowP1 <= curRow - ROW_FIRST;
            colP1 <= curCol - COL_FIRST;
        end
    end

    assign win_row = rowP1;
    assign win_col = colP1;
`else
    assign win_row = '0;
    assign win_col = '0;
`endif

endmodule

// File: tb/tb_image_window_gen.sv
// Bench for image_window_gen: random stimulus against an image-array reference model,
// on an 8x6 / WIN=3 instance and a 16x8 / WIN=8 instance.
module tb_image_window_gen;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int AH   = 6;
    localparam int AWIN = 3;
    localparam int AWB  = AWIN * AWIN * DW;
    localparam int BW   = 16;
    localparam int BH   = 8;
    localparam int BWIN = 8;
    localparam int BWB  = BWIN * BWIN * DW;

`ifdef WIN_COORD_EN
    localparam bit COORD_EN = 1'b1;
`else
    localparam bit COORD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]     pixel;
    logic           pixel_valid, pixel_ready, frame_sync;
    logic [AWB-1:0] window;
    logic           window_valid, window_ready, window_last;
    logic [2:0]     win_row, win_col;

    logic [7:0]     bPixel;
    logic           bPixelValid, bPixelReady, bFrameSync;
    logic [BWB-1:0] bWindow;
    logic           bWindowValid, bWindowReady, bWindowLast;
    logic [2:0]     bWinRow;
    logic [3:0]     bWinCol;

    image_window_gen #(.DATA_W(DW), .IMG_W(AW), .IMG_H(AH), .WIN(AWIN)) dutA (
        .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .frame_sync(frame_sync), .window(window),
        .window_valid(window_valid), .window_ready(window_ready),
        .window_last(window_last), .win_row(win_row), .win_col(win_col)
    );

    image_window_gen #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH), .WIN(BWIN)) dutB (
        .clk(clk), .reset(reset), .pixel(bPixel), .pixel_valid(bPixelValid),
        .pixel_ready(bPixelReady), .frame_sync(bFrameSync), .window(bWindow),
        .window_valid(bWindowValid), .window_ready(bWindowReady),
        .window_last(bWindowLast), .win_row(bWinRow), .win_col(bWinCol)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic checkValue(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the current frame as a 2-D image, windows cut straight out of it.
    typedef struct {
        logic [AWB-1:0] win;
        bit             last;
        int             row;
        int             col;
    } expWin_t;

    expWin_t    expQ[$];
    logic [7:0] img [AH][AW];
    int         mRow = 0, mCol = 0;

    task automatic modelAccept(input logic [7:0] px, input logic fs, output bit emitted);
        expWin_t e;
        emitted = 1'b0;
        if (fs) begin
            mRow = 0;
            mCol = 0;
        end
        img[mRow][mCol] = px;
        if (mRow >= AWIN - 1 && mCol >= AWIN - 1) begin
            e.win = '0;
            for (int r = 0; r < AWIN; r++)
                for (int c = 0; c < AWIN; c++)
                    e.win[(r*AWIN+c)*DW +: DW] = img[mRow-AWIN+1+r][mCol-AWIN+1+c];
            e.last = (mRow == AH - 1) && (mCol == AW - 1);
            e.row  = mRow - AWIN + 1;
            e.col  = mCol - AWIN + 1;
            expQ.push_back(e);
            emitted = 1'b1;
        end
        if (mCol == AW - 1) begin
            mCol = 0;
            mRow = (mRow == AH - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
    endtask

    // Window starting at raster index base of the source pattern (value = row*16+col).
    function automatic logic [AWB-1:0] mkWinA(input int base);
        logic [AWB-1:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < AWIN; r++)
            for (int c = 0; c < AWIN; c++) begin
                idx = (base + r * AW + c) % (AW * AH);
                w[(r*AWIN+c)*DW +: DW] = 8'((idx / AW) * 16 + idx % AW);
            end
        return w;
    endfunction

    function automatic logic [BWB-1:0] mkWinB(input int k);
        logic [BWB-1:0] w;
        w = '0;
        for (int r = 0; r < BWIN; r++)
            for (int c = 0; c < BWIN; c++)
                w[(r*BWIN+c)*DW +: DW] = 8'(r * 16 + k + c);
        return w;
    endfunction

    bit             emitPrev = 0, hsPrev = 0, heldPrev = 0;
    logic [AWB-1:0] heldWin;
    logic           heldLast;
    logic [2:0]     heldRow, heldCol;
    int             winCount = 0, lastCount = 0;
    bit             capArm = 0;
    logic [AWB-1:0] capWin;
    logic [7:0]     lastCorner;

    always @(negedge clk) begin : monA
        expWin_t e;
        bit emitNow;
        bit hsNow;
        emitNow = 1'b0;
        hsNow   = 1'b0;
        if (!reset) begin
            emitPrev = 1'b0;
            hsPrev   = 1'b0;
            heldPrev = 1'b0;
        end else begin
            if (emitPrev) checkValue("latency_valid", window_valid, 1'b1);
            else if (hsPrev) checkValue("valid_drop", window_valid, 1'b0);
            if (!window_valid) checkValue("ready_idle", pixel_ready, 1'b1);
            if (window_valid && !window_ready) begin
                checkValue("ready_while_held", pixel_ready, 1'b0);
                if (heldPrev) begin
                    checkValue("hold_window", window, heldWin);
                    checkValue("hold_last", window_last, heldLast);
                    checkValue("hold_row", win_row, heldRow);
                    checkValue("hold_col", win_col, heldCol);
                end
                heldPrev = 1'b1;
                heldWin  = window;
                heldLast = window_last;
                heldRow  = win_row;
                heldCol  = win_col;
            end else begin
                heldPrev = 1'b0;
            end
            if (window_valid && window_ready) begin
                hsNow = 1'b1;
                if (expQ.size() == 0) begin
                    checkValue("spurious_window", window_valid, 1'b0);
                end else begin
                    e = expQ.pop_front();
                    checkValue("window", window, e.win);
                    checkValue("window_last", window_last, e.last);
                    checkValue("win_row", win_row, COORD_EN ? e.row : 0);
                    checkValue("win_col", win_col, COORD_EN ? e.col : 0);
                    winCount++;
                    if (window_last) begin
                        lastCount++;
                        lastCorner = window[(2*AWIN+2)*DW +: DW];
                    end
                    if (capArm) begin
                        capWin = window;
                        capArm = 1'b0;
                    end
                end
            end
            if (pixel_valid && pixel_ready) modelAccept(pixel, frame_sync, emitNow);
            emitPrev = emitNow;
            hsPrev   = hsNow;
        end
    end

    int         bCount = 0, bLastCount = 0;
    logic [7:0] bLastCorner = '0;

    always @(negedge clk) begin : monB
        if (reset && bWindowValid) begin
            checkValue("b_window", bWindow, mkWinB(bCount));
            checkValue("b_last", bWindowLast, bCount == BW - BWIN);
            checkValue("b_win_row", bWinRow, 0);
            checkValue("b_win_col", bWinCol, COORD_EN ? bCount : 0);
            if (bWindowLast) begin
                bLastCount++;
                bLastCorner = bWindow[(7*BWIN+7)*DW +: DW];
            end
            bCount++;
        end
    end

    int readyPct = 100;
    initial begin
        window_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            window_ready = ($urandom_range(99) < readyPct);
        end
    end

    int sRow = 0, sCol = 0;

    task automatic sendPix(input bit fs, input int gapMax);
        int g;
        int n;
        g = (gapMax > 0) ? $urandom_range(gapMax) : 0;
        pixel_valid = 1'b0;
        repeat (g) begin
            pixel = 8'($urandom);
            @(posedge clk);
            #1;
        end
        pixel       = {4'(sRow), 4'(sCol)};
        frame_sync  = fs;
        pixel_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pixel_ready) break;
            n++;
            if (n > 500) begin
                checkValue("accept_timeout", pixel_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        frame_sync  = 1'b0;
        pixel       = 8'($urandom);
        if (sCol == AW - 1) begin
            sCol = 0;
            sRow = (sRow == AH - 1) ? 0 : sRow + 1;
        end else begin
            sCol++;
        end
    endtask

    task automatic sendN(input int n, input bit syncFirst, input int gapMax);
        for (int i = 0; i < n; i++) sendPix(syncFirst && (i == 0), gapMax);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || window_valid) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkValue("drain_pending", expQ.size(), 0);
    endtask

    task automatic clearCounts();
        winCount   = 0;
        lastCount  = 0;
        lastCorner = '0;
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: observed no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        pixel = '0; pixel_valid = 1'b0; frame_sync = 1'b0;
        bPixel = '0; bPixelValid = 1'b0; bFrameSync = 1'b0; bWindowReady = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkValue("rst_window_valid", window_valid, 1'b0);
        checkValue("rst_pixel_ready", pixel_ready, 1'b1);
        checkValue("rst_window", window, 0);
        checkValue("rst_window_last", window_last, 1'b0);
        checkValue("rst_win_row", win_row, 0);
        checkValue("rst_win_col", win_col, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First window and full-frame count, streaming without stalls
        clearCounts();
        capArm = 1'b1;
        sendN(AW * AH, 1'b1, 0);
        drain();
        checkValue("first_window", capWin, mkWinA(0));
        checkValue("frame_windows", winCount, 24);
        checkValue("frame_last_count", lastCount, 1);
        checkValue("frame_last_corner", lastCorner, 8'h57);

        // Two back-to-back frames
        clearCounts();
        sendN(2 * AW * AH, 1'b0, 0);
        drain();
        checkValue("two_frame_windows", winCount, 48);
        checkValue("two_frame_last_count", lastCount, 2);

        // Backpressure with 30% ready and random input gaps
        clearCounts();
        readyPct = 30;
        sendN(AW * AH, 1'b1, 2);
        drain();
        readyPct = 100;
        checkValue("bp_windows", winCount, 24);
        checkValue("bp_last_count", lastCount, 1);

        // Resync at source pixel (3,4)
        sRow = 0; sCol = 0;
        sendN(3 * AW + 4, 1'b1, 0);
        drain();
        clearCounts();
        capArm = 1'b1;
        sendPix(1'b1, 0);
        sendN(2 * AW + 2, 1'b0, 0);
        drain();
        checkValue("resync_windows", winCount, 1);
        checkValue("resync_first", capWin, mkWinA(3 * AW + 4));
        checkValue("resync_first_00", capWin[7:0], 8'h34);

        // Reset asserted right after accepting pixel (4,5)
        sRow = 0; sCol = 0;
        sendN(4 * AW + 6, 1'b1, 0);
        reset = 1'b0;
        #1;
        checkValue("midrst_window_valid", window_valid, 1'b0);
        checkValue("midrst_pixel_ready", pixel_ready, 1'b1);
        checkValue("midrst_window", window, 0);
        checkValue("midrst_window_last", window_last, 1'b0);
        expQ.delete();
        mRow = 0;
        mCol = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        sRow = 0; sCol = 0;
        clearCounts();
        capArm = 1'b1;
        sendN(AW * AH, 1'b0, 0);
        drain();
        checkValue("postrst_first_window", capWin, mkWinA(0));
        checkValue("postrst_windows", winCount, 24);
        checkValue("postrst_last_count", lastCount, 1);

        // Size sweep on the WIN=8 instance
        @(posedge clk);
        #1;
        for (int i = 0; i < BW * BH; i++) begin
            bPixel      = 8'(i);
            bPixelValid = 1'b1;
            bFrameSync  = (i == 0);
            @(negedge clk);
            checkValue("b_pixel_ready", bPixelReady, 1'b1);
            @(posedge clk);
            #1;
        end
        bPixelValid = 1'b0;
        bFrameSync  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkValue("b_windows", bCount, 9);
        checkValue("b_last_count", bLastCount, 1);
        checkValue("b_last_corner", bLastCorner, 8'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
